prog_sequencer: RTL
===================

# prog_sequencer

Hardware launch controller sitting directly upstream of `TopLevel`. Runs programs 0..NUM_PROGS-1 back to back from one `Go` request, driving `TopLevel`'s `Start` and consuming its `Ack` done flag. Measures the cycle count of each program and aborts on a hung program. It replaces the manual Start/wait(Ack) sequencing in the final-submission bench, so a single `Go` exercises P1, P2 and P3.

## Interface
Parameters:
- `NUM_PROGS`, 3: number of programs per batch (1..4).
- `CNT_W`, 16: cycle-counter width.
- `START_LEN`, 1: cycles `Start` is held high per launch (1..7).
- `TIMEOUT`, 16'hFFF0: cycle limit per program (used only with `PROG_SEQ_TIMEOUT_EN`).

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Go`  in  1  batch request; rising edge sampled.
- `Start`  out  1  to `TopLevel.Start`.
- `Ack`  in  1  from `TopLevel.Ack`.
- `ProgSel`  out  2  index of the program being launched or run.
- `CycleCnt`  out  CNT_W  running or final cycle count of the current program.
- `CntValid`  out  1  one-cycle pulse; `CycleCnt` is the final count of program `ProgSel`.
- `Busy`  out  1  high from launch to batch end.
- `BatchDone`  out  1  level; set at batch end, cleared by the next accepted `Go`.
- `TimedOut`  out  1  sticky; cleared by the next accepted `Go`.

## Operation
- States: IDLE, LAUNCH, RUN, RECORD, NEXT, DONE.
- Reset (any state, any time): state IDLE; all outputs 0; `GoPrev` and `AckPrev` 0; counters 0. No partial result survives.
- IDLE/DONE: `Go`=1 with `GoPrev`=0 is accepted.
  - On acceptance: `ProgSel`←0, clear `BatchDone`/`TimedOut`, `CycleCnt`←0, go to LAUNCH.
  - `Go` held high never retriggers. `Go` in any other state is ignored.
- LAUNCH: `Start`=1 for exactly START_LEN cycles (launch counter), then RUN.
- RUN:
  - `CycleCnt` increments each cycle, saturating at all-ones.
  - Completion = `Ack` rising edge (`Ack`=1, `AckPrev`=0). A stale `Ack` still high from the previous program is ignored until it has been seen low.
  - The completion cycle is counted; go to RECORD.
- RECORD: `CntValid`=1 for one cycle; `CycleCnt` frozen. If `ProgSel`=NUM_PROGS-1 go to DONE, else NEXT.
- NEXT: `ProgSel`+1, `CycleCnt`←0, go to LAUNCH.
- DONE: `Busy`=0, `BatchDone`=1; `ProgSel` and `CycleCnt` hold the last values.
- `Busy`=1 in LAUNCH, RUN, RECORD and NEXT.
- An `Ack` rise during LAUNCH is not a completion: `AckPrev` still tracks it, and it is ignored.

## Timing
- All outputs are registered; no combinational input→output path.
- `Go` rise sampled at edge N → `Start`=1 and `Busy`=1 from edge N+1 through N+START_LEN.
- First RUN cycle gives `CycleCnt`=1 after its edge.
- `Ack` rise sampled at edge M → `CntValid` high for the cycle after edge M+1, with `CycleCnt` = number of RUN cycles including M.
- Inter-program gap (RECORD + NEXT): 2 cycles before the next `Start`.
- `BatchDone` rises the cycle after the last RECORD.

## Configuration
- `PROG_SEQ_TIMEOUT_EN` defined:
  - If `CycleCnt` reaches TIMEOUT in RUN without completion: `TimedOut`←1, `CntValid` not pulsed, go directly to DONE.
  - Remaining programs are skipped; `ProgSel` holds the hung index.
- Undefined: RUN waits indefinitely; `TimedOut` tied 0; TIMEOUT unused.

## Test plan
- Reset mid-RUN (`ProgSel`=1, `CycleCnt`=40) → the cycle after `Reset` rises, all outputs are 0 and the state is IDLE, with no clock edge needed.
- NUM_PROGS=3, START_LEN=1; stub `Ack` rises after 10, 25 and 7 RUN cycles → `CntValid` pulses with (`ProgSel`,`CycleCnt`)=(0,10),(1,25),(2,7); `Start` is a 1-cycle pulse ×3; `BatchDone`=1; `TimedOut`=0.
- `Ack` held high from the previous program through LAUNCH, dropped at RUN cycle 3, re-risen at cycle 12 → single completion with `CycleCnt`=12.
- START_LEN=3 → each `Start` is exactly 3 cycles wide; the counter starts only after `Start` falls.
- `Go` held high across DONE, then a second `Go` pulse while `Busy` → no relaunch either time; the next clean `Go` rise clears `BatchDone` and restarts at `ProgSel`=0.
- `PROG_SEQ_TIMEOUT_EN`, TIMEOUT=20, program 1 never acks → `TimedOut`=1 at `CycleCnt`=20, `ProgSel`=1, `BatchDone`=1, only one `CntValid` pulse seen.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches NUM_PROGS programs on TopLevel back to back from one Go and times each.
// Defining PROG_SEQ_TIMEOUT_EN adds a per-program hang abort at TIMEOUT cycles.
module prog_sequencer #(
    parameter int               NUM_PROGS = 3,
    parameter int               CNT_W     = 16,
    parameter int               START_LEN = 1,
    parameter logic [CNT_W-1:0] TIMEOUT   = 16'hFFF0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    output logic             Start,
    input  logic             Ack,
    output logic [1:0]       ProgSel,
    output logic [CNT_W-1:0] CycleCnt,
    output logic             CntValid,
    output logic             Busy,
    output logic             BatchDone,
    output logic             TimedOut
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_RECORD = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_go_prev;
    logic             r_ack_prev;
    logic             r_timed_out;
    logic [2:0]       r_launch_cnt;
    logic             w_go_rise;
    logic             w_ack_rise;
    logic             w_launch_end;
    logic             w_last;
    logic             w_timeout;
    logic             w_start;
    logic             w_busy;
    logic             w_valid;
    logic             w_done;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_go_rise    = Go & ~r_go_prev;
    // A level still high from the previous program never looks like a rise.
    assign w_ack_rise   = Ack & ~r_ack_prev;
    assign w_launch_end = (r_launch_cnt == 3'(START_LEN - 1));
    assign w_last       = (ProgSel == 2'(NUM_PROGS - 1));
    assign w_cnt_inc    = (&CycleCnt) ? CycleCnt : CycleCnt + CNT_W'(1);
    assign TimedOut     = r_timed_out;

`ifdef PROG_SEQ_TIMEOUT_EN
    assign w_timeout = (w_cnt_inc == TIMEOUT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_go_rise ? S_LAUNCH : r_state;
            S_LAUNCH:       w_next = w_launch_end ? S_RUN : S_LAUNCH;
            S_RUN: begin
                if (w_ack_rise)     w_next = S_RECORD;
                else if (w_timeout) w_next = S_DONE;
                else                w_next = S_RUN;
            end
            S_RECORD:       w_next = w_last ? S_DONE : S_NEXT;
            S_NEXT:         w_next = S_LAUNCH;
            default:        w_next = S_IDLE;
        endcase
    end

    // Output decode of the current state, registered below.
    always_comb begin
        w_start = 1'b0;
        w_busy  = 1'b0;
        w_valid = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_LAUNCH: begin w_start = 1'b1; w_busy = 1'b1; end
            S_RUN:    w_busy = 1'b1;
            S_RECORD: begin w_valid = 1'b1; w_busy = 1'b1; end
            S_NEXT:   w_busy = 1'b1;
            S_DONE:   w_done = 1'b1;
            default:  w_busy = 1'b0;
        endcase
    end

    // Output registers, edge detectors, program index and counters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Start        <= 1'b0;
            Busy         <= 1'b0;
            CntValid     <= 1'b0;
            BatchDone    <= 1'b0;
            ProgSel      <= 2'd0;
            CycleCnt     <= '0;
            r_go_prev    <= 1'b0;
            r_ack_prev   <= 1'b0;
            r_timed_out  <= 1'b0;
            r_launch_cnt <= 3'd0;
        end else begin
            Start      <= w_start;
            Busy       <= w_busy;
            CntValid   <= w_valid;
            BatchDone  <= w_done;
            r_go_prev  <= Go;
            r_ack_prev <= Ack;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go_rise) begin
                        ProgSel     <= 2'd0;
                        CycleCnt    <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                S_LAUNCH: r_launch_cnt <= w_launch_end ? 3'd0 : r_launch_cnt + 3'd1;
                S_RUN: begin
                    CycleCnt <= w_cnt_inc;
                    if (!w_ack_rise && w_timeout) r_timed_out <= 1'b1;
                end
                S_NEXT: begin
                    ProgSel  <= ProgSel + 2'd1;
                    CycleCnt <= '0;
                end
                default: r_launch_cnt <= r_launch_cnt;
            endcase
        end
    end
endmodule
